// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/writeback
// sequencing with a bounded memory-ready wait and a sticky halt on illegal opcodes or bus errors.
module mips_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       halted,
    output logic       bus_error
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
    } state_t;

    // Registered per-state control word; fetch_hs/branch/jump qualify the input-dependent strobes.
    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] pc_src;
        logic       fetch_hs;
        logic       branch;
        logic       jump;
    } ctrl_t;

    state_t          state;
    state_t          state_next;
    ctrl_t           ctrl;
    logic [TO_W-1:0] cnt;
    logic [TO_W-1:0] cnt_next;
    logic            halted_q;
    logic            bus_error_q;
    logic            wait_st;
    logic            timeout;

    function automatic logic funct_ok(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
            default:                                               funct_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_alu = 3'b010;
        endcase
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] f);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read    = 1'b1;
                c.alu_src_b   = 2'b01;
                c.alu_control = 3'b010;
                c.fetch_hs    = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_b   = 2'b11;
                c.alu_control = 3'b010;
            end
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = 2'b10;
                c.alu_control = 3'b010;
            end
            S_MEMRD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = funct_alu(f);
            end
            S_ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = 3'b110;
                c.pc_src      = 2'b01;
                c.branch      = 1'b1;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            S_JUMP: begin
                c.pc_src = 2'b10;
                c.jump   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next state, with the memory wait timeout overriding any wait-state decision.
    always_comb begin
        state_next = state;
        wait_st    = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
        timeout    = wait_st && !mem_ready && (cnt == TO_W'(MEM_TIMEOUT));
        case (state)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_next = funct_ok(funct) ? S_EXEC : S_HALT;
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_HALT;
                endcase
            end
            S_MEMADR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_next = S_FETCH;
            S_EXEC:   state_next = S_ALUWB;
            S_ADDIEX: state_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_HALT;
        endcase
        if (timeout) state_next = S_HALT;
        if (!wait_st || mem_ready || (state_next != state)) cnt_next = '0;
        else                                                cnt_next = cnt + TO_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_FETCH;
            ctrl        <= decode_ctrl(S_FETCH, 6'd0);
            cnt         <= '0;
            halted_q    <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state <= state_next;
            ctrl  <= decode_ctrl(state_next, funct);
            cnt   <= cnt_next;
            if (state_next == S_HALT) halted_q <= 1'b1;
            if (timeout)              bus_error_q <= 1'b1;
        end
    end

    // Reset masks every output immediately so an in-flight write strobe cannot survive it.
    always_comb begin
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        pc_src      = 2'b00;
        pc_en       = 1'b0;
        halted      = 1'b0;
        bus_error   = 1'b0;
        if (!reset) begin
            iord        = ctrl.iord;
            mem_read    = ctrl.mem_read;
            mem_write   = ctrl.mem_write;
            ir_write    = ctrl.fetch_hs & mem_ready;
            reg_dst     = ctrl.reg_dst;
            mem_to_reg  = ctrl.mem_to_reg;
            reg_write   = ctrl.reg_write;
            alu_src_a   = ctrl.alu_src_a;
            alu_src_b   = ctrl.alu_src_b;
            alu_control = ctrl.alu_control;
            pc_src      = ctrl.pc_src;
            pc_en       = (ctrl.fetch_hs & mem_ready) | (ctrl.branch & zero) | ctrl.jump;
            halted      = halted_q;
            bus_error   = bus_error_q;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: a micro-op sequence model checked every cycle,
// plus directed instruction runs with hand-computed per-cycle strobe masks.
module tb_mips_multicycle_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h20;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, pc_en, halted, bus_error;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(TO), .TO_W(3)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .pc_src(pc_src), .pc_en(pc_en), .halted(halted),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    logic [17:0] obs;
    assign obs = {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, alu_control, pc_src, pc_en, halted, bus_error};

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Micro-op kinds and instruction classes of the reference model.
    localparam int U_FETCH = 0, U_DEC = 1, U_ADR = 2, U_RD = 3, U_RDWB = 4, U_WR = 5;
    localparam int U_EXE = 6, U_EXWB = 7, U_BR = 8, U_AIEX = 9, U_AIWB = 10, U_JMP = 11;
    localparam int U_HALT = 12;
    localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_ADDI = 4, C_J = 5, C_BAD = 6;

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                case (fn)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: return C_R;
                    default: return C_BAD;
                endcase
            end
            6'h23: return C_LW;
            6'h2B: return C_SW;
            6'h04: return C_BEQ;
            6'h08: return C_ADDI;
            6'h02: return C_J;
            default: return C_BAD;
        endcase
    endfunction

    function automatic int seq_len(input int cls);
        case (cls)
            C_LW:         return 5;
            C_BEQ, C_J:   return 3;
            default:      return 4;
        endcase
    endfunction

    // Every instruction is FETCH, DECODE, then a class-specific tail.
    function automatic int uop_at(input int cls, input int idx);
        if (idx == 0) return U_FETCH;
        if (idx == 1) return U_DEC;
        case (cls)
            C_R:    return (idx == 2) ? U_EXE : U_EXWB;
            C_LW:   return (idx == 2) ? U_ADR : ((idx == 3) ? U_RD : U_RDWB);
            C_SW:   return (idx == 2) ? U_ADR : U_WR;
            C_BEQ:  return U_BR;
            C_ADDI: return (idx == 2) ? U_AIEX : U_AIWB;
            default: return U_JMP;
        endcase
    endfunction

    function automatic logic [17:0] exp_vec(input int u, input logic [5:0] fn, input logic z,
                                            input logic rdy, input logic be);
        logic io, mr, mw, irw, rd, m2r, rw, asa, pce, h;
        logic [1:0] asb, pcs;
        logic [2:0] alu;
        {io, mr, mw, irw, rd, m2r, rw, asa, pce, h} = '0;
        asb = 2'b00; pcs = 2'b00; alu = 3'b000;
        case (u)
            U_FETCH: begin mr = 1; asb = 2'b01; alu = 3'b010; irw = rdy; pce = rdy; end
            U_DEC:   begin asb = 2'b11; alu = 3'b010; end
            U_ADR, U_AIEX: begin asa = 1; asb = 2'b10; alu = 3'b010; end
            U_RD:    begin io = 1; mr = 1; end
            U_RDWB:  begin m2r = 1; rw = 1; end
            U_WR:    begin io = 1; mw = 1; end
            U_EXE: begin
                asa = 1;
                case (fn)
                    6'h22:   alu = 3'b110;
                    6'h24:   alu = 3'b000;
                    6'h25:   alu = 3'b001;
                    6'h2A:   alu = 3'b111;
                    default: alu = 3'b010;
                endcase
            end
            U_EXWB:  begin rd = 1; rw = 1; end
            U_BR:    begin asa = 1; alu = 3'b110; pcs = 2'b01; pce = z; end
            U_AIWB:  rw = 1;
            U_JMP:   begin pcs = 2'b10; pce = 1; end
            default: h = 1;
        endcase
        return {io, mr, mw, irw, rd, m2r, rw, asa, asb, alu, pcs, pce, h, (h & be)};
    endfunction

    int m_cls = C_R;
    int m_idx = 0;
    int m_wait = 0;
    bit m_halt = 1'b0;
    bit m_be = 1'b0;

    // Model: advance through the instruction's micro-ops; memory micro-ops wait on mem_ready.
    always @(posedge clk or posedge reset) begin : model
        int u;
        bit adv;
        if (reset) begin
            m_cls = C_R; m_idx = 0; m_wait = 0; m_halt = 1'b0; m_be = 1'b0;
        end else if (!m_halt) begin
            u = uop_at(m_cls, m_idx);
            adv = 1'b0;
            if (u == U_FETCH || u == U_RD || u == U_WR) begin
                if (mem_ready)         adv = 1'b1;
                else if (m_wait == TO) begin m_halt = 1'b1; m_be = 1'b1; end
                else                   m_wait++;
            end else if (u == U_DEC) begin
                m_cls = classify(opcode, funct);
                if (m_cls == C_BAD) m_halt = 1'b1;
                else                adv = 1'b1;
            end else begin
                adv = 1'b1;
            end
            if (adv) begin
                m_wait = 0;
                m_idx = (m_idx + 1 >= seq_len(m_cls)) ? 0 : m_idx + 1;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [17:0] e;
        if (reset) e = '0;
        else       e = exp_vec(m_halt ? U_HALT : uop_at(m_cls, m_idx), funct, zero, mem_ready, m_be);
        check("model", 32'(obs), 32'(e));
    end

    logic [31:0] ob_irw, ob_fetch, ob_rdmem, ob_ldwb, ob_pcen, ob_br, ob_halt, ob_be;
    logic [31:0] ob_strobe, ob_mw, ob_mr, ob_dec, ob_exadd, ob_rwrd;

    // Drives one instruction for n cycles (mem_ready per cycle from rmask) and records strobe masks.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic [31:0] rmask, input int n);
        {ob_irw, ob_fetch, ob_rdmem, ob_ldwb, ob_pcen, ob_br, ob_halt} = '0;
        {ob_be, ob_strobe, ob_mw, ob_mr, ob_dec, ob_exadd, ob_rwrd} = '0;
        for (int i = 0; i < n; i++) begin
            opcode = op; funct = fn; zero = z; mem_ready = rmask[i];
            @(negedge clk);
            ob_irw[i]    = ir_write;
            ob_fetch[i]  = mem_read & ~iord;
            ob_rdmem[i]  = mem_read & iord;
            ob_ldwb[i]   = reg_write & mem_to_reg;
            ob_pcen[i]   = pc_en;
            ob_br[i]     = pc_en && (pc_src == 2'b01);
            ob_halt[i]   = halted;
            ob_be[i]     = bus_error;
            ob_strobe[i] = mem_read | mem_write | reg_write | ir_write | pc_en;
            ob_mw[i]     = mem_write;
            ob_mr[i]     = mem_read;
            ob_dec[i]    = (alu_src_b == 2'b11);
            ob_exadd[i]  = alu_src_a && (alu_src_b == 2'b00) && (alu_control == 3'b010);
            ob_rwrd[i]   = reg_write & reg_dst;
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check("reset_outs", 32'(obs), 32'h0);
        reset = 1'b0;
        opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1;
        #1;
        check("fetch_vec", 32'(obs), 32'(18'b010100000101000100));

        run(6'h00, 6'h20, 1'b0, 32'h0F, 5);
        check("radd_fetch", ob_fetch, 32'h11);
        check("radd_irw", ob_irw, 32'h01);
        check("radd_exec", ob_exadd, 32'h04);
        check("radd_wb", ob_rwrd, 32'h08);

        run(6'h23, 6'h00, 1'b0, 32'h0C7, 9);
        check("lw_rdmem", ob_rdmem, 32'h78);
        check("lw_wb", ob_ldwb, 32'h80);
        check("lw_fetch", ob_fetch, 32'h101);

        run(6'h04, 6'h00, 1'b1, 32'h07, 4);
        check("beq1_pcen", ob_pcen, 32'h5);
        check("beq1_br", ob_br, 32'h4);
        run(6'h04, 6'h00, 1'b0, 32'h07, 4);
        check("beq0_pcen", ob_pcen, 32'h1);
        check("beq0_fetch", ob_fetch, 32'h9);

        run(6'h00, 6'h22, 1'b0, 32'h0F, 5);
        check("rsub_exadd", ob_exadd, 32'h0);
        run(6'h08, 6'h00, 1'b0, 32'h0F, 5);
        check("addi_fetch", ob_fetch, 32'h11);
        run(6'h02, 6'h00, 1'b0, 32'h07, 4);
        check("j_pcen", ob_pcen, 32'h5);

        run(6'h3F, 6'h00, 1'b0, 32'h0F, 4);
        check("ill_halt", ob_halt, 32'hC);
        check("ill_be", ob_be, 32'h0);
        check("ill_strobe", ob_strobe, 32'h1);
        do_reset();
        #1;
        check("ill_recover", 32'({halted, mem_read, iord}), 32'b010);

        run(6'h00, 6'h20, 1'b0, 32'h00, 7);
        check("to_mr", ob_mr, 32'h1F);
        check("to_halt", ob_halt, 32'h60);
        check("to_be", ob_be, 32'h60);
        do_reset();

        run(6'h00, 6'h20, 1'b0, 32'h70, 7);
        check("late_irw", ob_irw, 32'h10);
        check("late_halt", ob_halt, 32'h0);
        check("late_dec", ob_dec, 32'h20);
        check("late_exec", ob_exadd, 32'h40);
        do_reset();

        run(6'h2B, 6'h00, 1'b0, 32'h07, 4);
        check("sw_mw", ob_mw, 32'h8);
        #1;
        check("sw_hold", 32'(mem_write), 32'h1);
        reset = 1'b1;
        #1;
        check("sw_abort", 32'(obs), 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("sw_refetch", 32'({mem_read, iord, mem_write}), 32'b100);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback over shared ALU, register file, unified memory port and immediate sign-extension path.
- Waits on a memory ready handshake with a bounded timeout.
- Flags illegal opcodes and bus errors by entering a sticky HALT state.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory access may wait for mem_ready before bus error (>=1)
TO_W, 5, timeout counter width; must hold MEM_TIMEOUT

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-high reset
opcode  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
iord  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  load instruction register
reg_dst  out  1  write reg select: 0=rt, 1=rd
mem_to_reg  out  1  writeback select: 0=ALUOut, 1=MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2
alu_control  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
pc_en  out  1  PC load enable
halted  out  1  sticky; controller stopped
bus_error  out  1  sticky; memory timeout cause of halt

Behaviour:
- Moore FSM; all outputs decode from state (plus zero and mem_ready where noted). Unlisted outputs are 0 in each state.
- Reset: state=FETCH, timeout counter=0, halted=0, bus_error=0. All outputs forced to 0 while reset is high.
- Supported opcodes: R-type 000000 (funct add 100000, sub 100010, and 100100, or 100101, slt 101010), lw 100011, sw 101011, beq 000100, addi 001000, j 000010. Any other opcode or R-type funct is illegal.
- FETCH:
  - iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00.
  - ir_write and pc_en are asserted only in the cycle mem_ready=1; that cycle goes to DECODE, otherwise stay.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_control=010 (branch target into ALUOut).
  - Next state: lw/sw->MEMADR, R-type->EXEC, beq->BRANCH, addi->ADDIEX, j->JUMP, illegal->HALT.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_control=010; lw->MEMRD, sw->MEMWR.
- MEMRD: iord=1, mem_read=1; on mem_ready->MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; ->FETCH.
- MEMWR: iord=1, mem_write=1; on mem_ready->FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_control from funct; ->ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1; ->FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01, pc_en=zero; ->FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_control=010; ->ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1; ->FETCH.
- JUMP: pc_src=10, pc_en=1; ->FETCH.
- HALT: halted=1; all strobes 0; leaves only on reset.
- Memory wait states (FETCH, MEMRD, MEMWR):
  - Counter clears on entry and on mem_ready. It increments each waiting cycle with mem_ready=0.
  - When counter reaches MEM_TIMEOUT with mem_ready still 0: bus_error=1, next state HALT, and the request strobe drops next cycle.
  - mem_ready arriving in the same cycle the count hits MEM_TIMEOUT wins: no error.
- mem_ready outside a wait state is ignored.
- Reset mid-access (any state) aborts immediately. No write strobe is asserted while reset is high.

Test Plan:
- Reset, mem_ready=1 always, R-type add (op 000000, funct 100000) -> FETCH(1 cycle, ir_write=pc_en=1), DECODE, EXEC alu_control=010, ALUWB reg_write=1 reg_dst=1, back to FETCH; 4 cycles total.
- lw with mem_ready delayed 3 cycles in MEMRD -> mem_read=1 iord=1 held 4 cycles, then MEMWB mem_to_reg=1 reg_write=1; 5+3=8 cycles total.
- beq with zero=1, then zero=0 -> pc_en=1 pc_src=01 in BRANCH for the first; pc_en=0 for the second; both return to FETCH.
- Opcode 111111 in DECODE -> HALT next cycle, halted=1, bus_error=0, all strobes 0; reset restores FETCH.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> bus_error=1 and halted=1 after timeout. With mem_ready=1 exactly at count 4 -> no error, DECODE entered.
- Reset asserted mid-MEMWR -> mem_write drops in the same cycle; after release, state=FETCH with mem_read=1.
